ccff_loader: RTL

CCFF_LOADER -- requirements
Module: ccff_loader

---
 rtl/ccff_loader.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/ccff_loader.sv
// Streams a packed bitstream into a configuration flip-flop chain, MSB first,
// and reassembles the bits returned from the chain tail into readback words.
module ccff_loader #(
  parameter int CHAIN_LEN = 36,
  parameter int DATA_W    = 8
) (
  input  logic                               prog_clk,
  input  logic                               pReset_n,
  input  logic                               start,
  input  logic                               abort,
  input  logic                               din_valid,
  input  logic [DATA_W-1:0]                  din_data,
  output logic                               din_ready,
  output logic                               ccff_head,
  output logic                               ccff_clk_en,
  input  logic                               ccff_tail,
  output logic                               busy,
  output logic                               done,
  output logic [$clog2(CHAIN_LEN+1)-1:0]     bit_count,
  output logic [DATA_W-1:0]                  tail_data,
  output logic                               tail_valid
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int REM_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   bit_buf;
  logic [REM_W-1:0]    rem;
  logic [DATA_W-1:0]   tail_sr;
  logic [REM_W-1:0]    tail_cnt;
  logic                tail_pulse;

  logic                in_load;
  logic                shifting;
  logic                shift_en;
  logic                last_shift;
  logic                accept;
  logic                session_start;
  logic [CNT_W:0]      committed;
  logic [CNT_W:0]      owed;
  logic [REM_W-1:0]    load_rem;
  logic [DATA_W-1:0]   tail_next;
  logic [REM_W-1:0]    tail_fill;
  logic                tail_full;
  logic [DATA_W-1:0]   tail_aligned;

  // Bits already shifted plus bits still sitting in the buffer; anything
  // beyond that up to CHAIN_LEN is still owed by the source.
  assign committed = {1'b0, bit_count} + (CNT_W+1)'(rem);
  assign owed      = (CNT_W+1)'(CHAIN_LEN) - committed;
  assign load_rem  = (owed >= (CNT_W+1)'(DATA_W)) ? REM_W'(DATA_W) : REM_W'(owed);

  assign in_load       = (state == S_LOAD);
  assign shifting      = in_load && (rem != '0);
  assign shift_en      = shifting && !abort;
  assign last_shift    = shifting && (bit_count == CNT_W'(CHAIN_LEN - 1));
  assign session_start = (state == S_IDLE) && start && !abort;

  assign din_ready = in_load && (rem <= REM_W'(1)) && (committed < (CNT_W+1)'(CHAIN_LEN));
  assign accept    = din_valid && din_ready && !abort;

  assign ccff_clk_en = shift_en;
  assign ccff_head   = shifting & bit_buf[DATA_W-1];
  assign busy        = in_load;
  assign done        = (state == S_DONE) && !abort;
  assign tail_valid  = tail_pulse && !abort;

  // Tail assembler: the sample taken this cycle lands in the LSB; a short
  // final word is shifted up so it reads left-justified with zero padding.
  assign tail_next    = {tail_sr[DATA_W-2:0], ccff_tail};
  assign tail_fill    = tail_cnt + REM_W'(1);
  assign tail_full    = (tail_fill == REM_W'(DATA_W));
  assign tail_aligned = tail_next << (REM_W'(DATA_W) - tail_fill);

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output of a combinational block is assigned a default first,
  // so no path through the case statement can leave a latch behind.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start && !abort) state_nxt = S_LOAD;
      S_LOAD: begin
        if (abort)                       state_nxt = S_IDLE;
        else if (shift_en && last_shift) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values and the later accept branch can
  // override the shift of the buffer without ordering hazards.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      bit_buf    <= '0;
      rem        <= '0;
      bit_count  <= '0;
      tail_sr    <= '0;
      tail_cnt   <= '0;
      tail_data  <= '0;
      tail_pulse <= 1'b0;
    end else begin
      tail_pulse <= 1'b0;

      if (session_start) begin
        bit_buf   <= '0;
        rem       <= '0;
        bit_count <= '0;
        tail_sr   <= '0;
        tail_cnt  <= '0;
      end

      if (shift_en) begin
        bit_count <= bit_count + CNT_W'(1);
        bit_buf   <= bit_buf << 1;
        rem       <= rem - REM_W'(1);
        tail_sr   <= tail_next;
        tail_cnt  <= tail_full ? '0 : tail_fill;
        if (tail_full) begin
          tail_data  <= tail_next;
          tail_pulse <= 1'b1;
        end else if (last_shift) begin
          tail_data  <= tail_aligned;
          tail_pulse <= 1'b1;
        end
      end

      // A new word replaces the buffer on the same edge that shifts out the
      // last old bit. Low bits of a short final word load but are never
      // shifted because rem only covers the owed bits.
      if (accept) begin
        bit_buf <= din_data;
        rem     <= load_rem;
      end
    end
  end

endmodule
